// File: rtl/stream_sequencer.sv
// stream_sequencer: packet parser feeding a sample FIFO and modulator run control; define SEQ_WATCHDOG_EN for the mid-packet idle watchdog
module stream_sequencer #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int DEPTH_WIDTH = 10,
  parameter int PREFILL = 512,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data_si,
  input  logic                   rx_valid_si,
  output logic                   rx_ready_si,
  output logic [7:0]             fifo_wr_data,
  output logic                   fifo_wr_en,
  input  logic                   fifo_full,
  input  logic                   fifo_empty,
  input  logic [DEPTH_WIDTH:0]   fifo_level,
  output logic                   mod_enable,
  output logic [7:0]             mod_cfg,
  output logic                   underrun,
  output logic [7:0]             err_cnt
);
  typedef enum logic [2:0] {HUNT, CMD, LEN, PAYLOAD, DISCARD} p_state_t;
  typedef enum logic [1:0] {IDLE, ARMED, RUN} r_state_t;
  localparam logic [7:0] C_DATA = 8'h01;
  localparam logic [7:0] C_CFG = 8'h02;
  localparam logic [7:0] C_START = 8'h03;
  localparam logic [7:0] C_STOP = 8'h04;
  localparam logic [DEPTH_WIDTH:0] PREFILL_LVL = PREFILL[DEPTH_WIDTH:0];
  p_state_t p_state, p_nxt;
  r_state_t r_state, r_nxt;
  logic [7:0] cmd, cnt;
  logic cfg_first, acc, is_data, known, len_acc, start_evt, stop_evt, und_evt, err_inc, wd_to;
  assign is_data = p_state == PAYLOAD && cmd == C_DATA;
  assign rx_ready_si = !rst || !(is_data && fifo_full);
  assign acc = rx_valid_si && rx_ready_si;
  assign fifo_wr_data = rx_data_si;
  assign fifo_wr_en = rst && is_data && acc;
  assign known = cmd inside {C_DATA, C_CFG, C_START, C_STOP};
  assign len_acc = p_state == LEN && acc;
  assign start_evt = len_acc && cmd == C_START;
  assign stop_evt = len_acc && cmd == C_STOP;
  assign und_evt = r_state == RUN && fifo_empty && !stop_evt;
  assign err_inc = (len_acc && rx_data_si != 8'd0 && !known) || wd_to;
`ifdef SEQ_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_cnt;
  assign wd_to = p_state != HUNT && !acc && wd_cnt == WW'(TIMEOUT - 1);
  always_ff @(posedge clk)
    wd_cnt <= (!rst || p_state == HUNT || acc || wd_to) ? '0 : wd_cnt + WW'(1);
`else
  assign wd_to = TIMEOUT < 0;
`endif
  always_comb begin
    p_nxt = p_state;
    if (wd_to)
      p_nxt = HUNT;
    else if (acc)
      case (p_state)
        HUNT: p_nxt = rx_data_si == SYNC_BYTE ? CMD : HUNT;
        CMD: p_nxt = LEN;
        LEN: p_nxt = rx_data_si == 8'd0 ? HUNT : known ? PAYLOAD : DISCARD;
        PAYLOAD, DISCARD: p_nxt = cnt == 8'd1 ? HUNT : p_state;
        default: p_nxt = HUNT;
      endcase
  end
  always_comb begin
    r_nxt = stop_evt ? IDLE :
            r_state == IDLE ? (start_evt ? ARMED : IDLE) :
            r_state == ARMED ? (fifo_level >= PREFILL_LVL ? RUN : ARMED) :
            r_state == RUN ? (fifo_empty ? ARMED : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      p_state <= HUNT;
      r_state <= IDLE;
    end else begin
      p_state <= p_nxt;
      r_state <= r_nxt;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd <= 8'd0;
      cnt <= 8'd0;
      cfg_first <= 1'b0;
      mod_cfg <= 8'd0;
      mod_enable <= 1'b0;
      underrun <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      mod_enable <= r_nxt == RUN;
      underrun <= und_evt;
      if (err_inc && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
      if (acc && p_state == CMD)
        cmd <= rx_data_si;
      if (len_acc) begin
        cnt <= rx_data_si;
        cfg_first <= 1'b1;
      end else if (acc && (p_state == PAYLOAD || p_state == DISCARD)) begin
        cnt <= cnt - 8'd1;
        cfg_first <= 1'b0;
      end
      if (acc && p_state == PAYLOAD && cmd == C_CFG && cfg_first)
        mod_cfg <= rx_data_si;
    end
  end
endmodule

// File: tb/tb_stream_sequencer.sv
// tb_stream_sequencer: directed self-checking bench for stream_sequencer
module tb_stream_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] rx_data_si = 8'd0;
  logic rx_valid_si = 1'b0;
  logic fifo_full = 1'b0;
  logic [10:0] fifo_level = 11'd0;
  logic fifo_empty, rx_ready_si, fifo_wr_en, mod_enable, underrun;
  logic [7:0] fifo_wr_data, mod_cfg, err_cnt;
  logic [7:0] last_wr = 8'd0;
  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt = 0;
  int bad_wr = 0;
  int w0;
  assign fifo_empty = fifo_level == 11'd0;
  always #5 clk = ~clk;
  stream_sequencer dut (
    .clk(clk), .rst(rst),
    .rx_data_si(rx_data_si), .rx_valid_si(rx_valid_si), .rx_ready_si(rx_ready_si),
    .fifo_wr_data(fifo_wr_data), .fifo_wr_en(fifo_wr_en),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_level(fifo_level),
    .mod_enable(mod_enable), .mod_cfg(mod_cfg), .underrun(underrun), .err_cnt(err_cnt)
  );
  always @(posedge clk)
    if (fifo_wr_en) begin
      wr_cnt <= wr_cnt + 1;
      last_wr <= fifo_wr_data;
      if (fifo_full)
        bad_wr <= bad_wr + 1;
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    logic w;
    rx_data_si = b;
    rx_valid_si = 1'b1;
    #1;
    while (!rx_ready_si && n < 50) begin
      tick();
      n++;
    end
    if (!rx_ready_si)
      check("ready_timeout", rx_ready_si, 1);
    w = fifo_wr_en;
    tick();
    rx_valid_si = 1'b0;
    if (w)
      fifo_level = fifo_level + 11'd1;
  endtask
  task automatic send_pkt(input logic [7:0] c, input int len, input logic [7:0] base);
    send(8'hA5);
    send(c);
    send(len[7:0]);
    for (int i = 0; i < len; i++)
      send(base + i[7:0]);
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rx_valid_si = 1'b1;
    rx_data_si = 8'hA5;
    repeat (3) tick();
    check("rst_ready", rx_ready_si, 1);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_mod_cfg", mod_cfg, 0);
    check("rst_mod_en", mod_enable, 0);
    check("rst_underrun", underrun, 0);
    check("rst_err", err_cnt, 0);
    rx_valid_si = 1'b0;
    rst = 1'b1;
    tick();
    w0 = wr_cnt;
    send(8'hA5);
    send(8'h02);
    send(8'h01);
    check("cfg_before", mod_cfg, 8'h00);
    send(8'h3C);
    check("cfg_load", mod_cfg, 8'h3C);
    check("cfg_no_wr", wr_cnt - w0, 0);
    send(8'hA5);
    send(8'h7F);
    send(8'h02);
    send(8'h11);
    send(8'h22);
    check("unknown_err", err_cnt, 1);
    send_pkt(8'h02, 1, 8'h05);
    check("after_discard", mod_cfg, 8'h05);
    send_pkt(8'h02, 0, 8'h00);
    check("cfg_len0", mod_cfg, 8'h05);
    send_pkt(8'h02, 3, 8'h77);
    check("cfg_extra", mod_cfg, 8'h77);
    check("err_stable", err_cnt, 1);
    send_pkt(8'h03, 0, 8'h00);
    check("armed_no_en", mod_enable, 0);
    w0 = wr_cnt;
    send_pkt(8'h01, 255, 8'h00);
    send_pkt(8'h01, 255, 8'h00);
    check("prefill_510", mod_enable, 0);
    send_pkt(8'h01, 2, 8'h00);
    check("en_at_512", mod_enable, 0);
    tick();
    check("en_after_512", mod_enable, 1);
    check("data_wr_cnt", wr_cnt - w0, 512);
    check("data_last", last_wr, 8'h01);
    fifo_level = 11'd0;
    tick();
    check("und_pulse", underrun, 1);
    check("und_en_off", mod_enable, 0);
    tick();
    check("und_once", underrun, 0);
    check("und_armed", mod_enable, 0);
    fifo_level = 11'd511;
    tick();
    check("rearm_511", mod_enable, 0);
    fifo_level = 11'd512;
    tick();
    check("rearm_512", mod_enable, 1);
    w0 = wr_cnt;
    send(8'hA5);
    send(8'h01);
    send(8'h02);
    fifo_full = 1'b1;
    rx_data_si = 8'hAB;
    rx_valid_si = 1'b1;
    #1;
    check("full_ready", rx_ready_si, 0);
    check("full_wr_en", fifo_wr_en, 0);
    repeat (3) tick();
    check("full_hold", rx_ready_si, 0);
    check("full_no_wr", wr_cnt - w0, 0);
    fifo_full = 1'b0;
    #1;
    check("release_wr_en", fifo_wr_en, 1);
    tick();
    rx_valid_si = 1'b0;
    fifo_level = fifo_level + 11'd1;
    check("held_once", wr_cnt - w0, 1);
    check("held_data", last_wr, 8'hAB);
    send(8'hCD);
    check("full_total", wr_cnt - w0, 2);
    check("full_last", last_wr, 8'hCD);
    send(8'hA5);
    send(8'h04);
    check("pre_stop", mod_enable, 1);
    send(8'h00);
    check("stop", mod_enable, 0);
    tick();
    check("stop_idle", mod_enable, 0);
    send_pkt(8'h03, 0, 8'h00);
    tick();
    check("restart", mod_enable, 1);
    send_pkt(8'h03, 0, 8'h00);
    check("start_in_run", mod_enable, 1);
    send(8'hA5);
    send(8'h04);
    fifo_level = 11'd0;
    send(8'h00);
    check("stop_und", underrun, 0);
    check("stop_und_en", mod_enable, 0);
    fifo_level = 11'd512;
    repeat (2) tick();
    check("idle_stays", mod_enable, 0);
    send_pkt(8'h03, 0, 8'h00);
    tick();
    check("run_again", mod_enable, 1);
    send(8'hA5);
    send(8'h01);
    send(8'h05);
    send(8'h10);
    w0 = wr_cnt;
    rx_data_si = 8'h20;
    rx_valid_si = 1'b1;
    rst = 1'b0;
    #1;
    check("rst_mid_ready", rx_ready_si, 1);
    check("rst_mid_wr_en", fifo_wr_en, 0);
    tick();
    rst = 1'b1;
    rx_valid_si = 1'b0;
    check("rst_mid_err", err_cnt, 0);
    check("rst_mid_en", mod_enable, 0);
    check("rst_mid_cfg", mod_cfg, 0);
    send(8'h11);
    send(8'h12);
    send(8'h13);
    check("rst_no_wr", wr_cnt - w0, 0);
    send_pkt(8'h02, 1, 8'h5A);
    check("rst_hunt", mod_cfg, 8'h5A);
    for (int i = 0; i < 255; i++)
      send_pkt(8'h7F, 1, 8'h00);
    check("err_255", err_cnt, 8'hFF);
    send_pkt(8'h7F, 1, 8'h00);
    check("err_sat", err_cnt, 8'hFF);
`ifdef SEQ_WATCHDOG_EN
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    send(8'hA5);
    repeat (1023) tick();
    check("wd_before", err_cnt, 0);
    tick();
    check("wd_fire", err_cnt, 1);
    send(8'h02);
    send(8'h01);
    send(8'h3C);
    check("wd_hunt_drop", mod_cfg, 8'h00);
    send_pkt(8'h02, 1, 8'h44);
    check("wd_hunt_cfg", mod_cfg, 8'h44);
`endif
    check("wr_into_full", bad_wr, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
